// File: rtl/bit_matrix_transposer.sv
// Double-buffered N x N bit-matrix transposer: row words in, column words out,
// with ready/valid on both sides, per-block mirror mode and a block-end marker.
module bit_matrix_transposer #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mirror,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last
);

  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] in_cnt_q, in_cnt_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic          fill_full_q, fill_full_d;
  logic          out_valid_q, out_valid_d;
  logic          fill_mirror_q, fill_mirror_d;
  logic          drain_mirror_q, drain_mirror_d;

  logic [N-1:0]  fill_q  [N];
  logic [N-1:0]  drain_q [N];

  logic          accept, complete, out_fire, drain_free, transfer;
  logic [CW-1:0] col;

  assign accept     = in_valid && !fill_full_q;
  assign complete   = accept && (in_cnt_q == LAST);
  assign out_fire   = out_valid_q && out_ready;
  // The drain is reusable on the very edge its last word leaves, so blocks chain with no bubble.
  assign drain_free = !out_valid_q || (out_fire && (out_cnt_q == LAST));
  assign transfer   = (complete || fill_full_q) && drain_free;

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    in_cnt_d       = in_cnt_q;
    out_cnt_d      = out_cnt_q;
    fill_full_d    = fill_full_q;
    out_valid_d    = out_valid_q;
    fill_mirror_d  = fill_mirror_q;
    drain_mirror_d = drain_mirror_q;

    if (accept) begin
      in_cnt_d = complete ? '0 : in_cnt_q + CW'(1);
      if (in_cnt_q == '0) fill_mirror_d = in_mirror;
    end

    if (out_fire) begin
      if (out_cnt_q == LAST) begin
        out_cnt_d   = '0;
        out_valid_d = 1'b0;
      end else begin
        out_cnt_d = out_cnt_q + CW'(1);
      end
    end

    if (transfer) begin
      fill_full_d    = 1'b0;
      out_valid_d    = 1'b1;
      out_cnt_d      = '0;
      drain_mirror_d = fill_mirror_q;
    end else if (complete) begin
      fill_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      in_cnt_q       <= '0;
      out_cnt_q      <= '0;
      fill_full_q    <= 1'b0;
      out_valid_q    <= 1'b0;
      fill_mirror_q  <= 1'b0;
      drain_mirror_q <= 1'b0;
    end else begin
      in_cnt_q       <= in_cnt_d;
      out_cnt_q      <= out_cnt_d;
      fill_full_q    <= fill_full_d;
      out_valid_q    <= out_valid_d;
      fill_mirror_q  <= fill_mirror_d;
      drain_mirror_q <= drain_mirror_d;
    end
  end

  // NOTE: the matrix storage is deliberately left without reset; validity is tracked by the control flops.
  always_ff @(posedge clk) begin
    if (accept) fill_q[in_cnt_q] <= in_data;
    if (transfer) begin
      for (int k = 0; k < N; k++) drain_q[k] <= fill_q[k];
      // The completing word is still on the input this edge, not yet in the fill buffer.
      if (complete) drain_q[N-1] <= in_data;
    end
  end

  assign col = drain_mirror_q ? (LAST - out_cnt_q) : out_cnt_q;

  always_comb begin
    out_data = '0;
    for (int k = 0; k < N; k++) out_data[k] = drain_q[k][col];
  end

  assign in_ready  = !fill_full_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_valid_q && (out_cnt_q == LAST);

endmodule

// File: tb/tb_bit_matrix_transposer.sv
// Directed bench for bit_matrix_transposer: N=16 main instance plus a small N=2 build.
module tb_bit_matrix_transposer;

  typedef logic [15:0] blk_t [16];

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data, out_data;
  logic        in_valid, in_ready, in_mirror, out_valid, out_ready, out_last;

  logic [1:0]  n2_in_data, n2_out_data;
  logic        n2_in_valid, n2_in_ready, n2_in_mirror, n2_out_valid, n2_out_ready, n2_out_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bit_matrix_transposer #(.N(16)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_mirror(in_mirror),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  bit_matrix_transposer #(.N(2)) dut2 (
    .clk(clk), .reset(reset),
    .in_data(n2_in_data), .in_valid(n2_in_valid), .in_ready(n2_in_ready), .in_mirror(n2_in_mirror),
    .out_data(n2_out_data), .out_valid(n2_out_valid), .out_ready(n2_out_ready), .out_last(n2_out_last)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference transpose: output word j, bit k = element (k, column j or N-1-j).
  function automatic void xpose(input blk_t b, input bit m, output blk_t o);
    for (int j = 0; j < 16; j++)
      for (int k = 0; k < 16; k++)
        o[j][k] = b[k][m ? 15 - j : j];
  endfunction

  // Push one block at full rate, then check its 16 output words (out_ready must be high).
  task automatic run_block(input blk_t b, input bit m, input blk_t e, input string tag);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check({tag, " in_ready"}, in_ready, 1'b1);
      in_valid  = 1'b1;
      in_data   = b[i];
      in_mirror = (i == 0) ? m : !m;
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int j = 0; j < 16; j++) begin
      check($sformatf("%s out_valid[%0d]", tag, j), out_valid, 1'b1);
      check($sformatf("%s out_data[%0d]", tag, j), out_data, e[j]);
      check($sformatf("%s out_last[%0d]", tag, j), out_last, j == 15);
      @(negedge clk);
    end
    check({tag, " idle after block"}, out_valid, 1'b0);
  endtask

  initial begin
    blk_t        b, e, ea, eb;
    logic [15:0] words [64];
    logic [15:0] expw  [64];
    logic [15:0] snap;
    int          acc;

    reset = 1'b1;
    in_data = '0; in_valid = 1'b0; in_mirror = 1'b0; out_ready = 1'b0;
    n2_in_data = '0; n2_in_valid = 1'b0; n2_in_mirror = 1'b0; n2_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset out_last", out_last, 1'b0);
    reset = 1'b0;
    out_ready = 1'b1;

    // Row 3 all ones -> every column word has only bit 3 set.
    for (int i = 0; i < 16; i++) begin b[i] = '0; e[i] = 16'h0008; end
    b[3] = 16'hFFFF;
    run_block(b, 1'b0, e, "row3");

    // Single element (0,0), mirrored: it appears in the last output word.
    for (int i = 0; i < 16; i++) begin b[i] = '0; e[i] = '0; end
    b[0] = 16'h0001; e[15] = 16'h0001;
    run_block(b, 1'b1, e, "mirror");
    e[15] = '0; e[0] = 16'h0001;
    run_block(b, 1'b0, e, "nomirror");

    // Back-to-back: four random blocks with both sides always ready.
    for (int i = 0; i < 64; i++) words[i] = 16'($urandom);
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 16; i++) b[i] = words[blk*16 + i];
      xpose(b, 1'b0, e);
      for (int i = 0; i < 16; i++) expw[blk*16 + i] = e[i];
    end
    for (int c = 0; c <= 80; c++) begin
      @(negedge clk);
      if (c >= 16 && c < 80) begin
        check($sformatf("b2b out_valid[%0d]", c - 16), out_valid, 1'b1);
        check($sformatf("b2b out_data[%0d]", c - 16), out_data, expw[c-16]);
        check($sformatf("b2b out_last[%0d]", c - 16), out_last, ((c - 16) % 16) == 15);
      end
      if (c == 80) check("b2b idle", out_valid, 1'b0);
      if (c < 64) begin
        check($sformatf("b2b in_ready[%0d]", c), in_ready, 1'b1);
        in_valid = 1'b1; in_data = words[c]; in_mirror = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
    end

    // Backpressure: downstream stalled, exactly two blocks fit; second block mirrored.
    out_ready = 1'b0;
    acc = 0;
    snap = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 20) snap = out_data;
      if (in_ready && acc < 64) begin
        in_valid  = 1'b1;
        in_data   = 16'($urandom);
        in_mirror = (acc == 16);
        words[acc] = in_data;
        acc++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) b[i] = words[i];
    xpose(b, 1'b0, ea);
    for (int i = 0; i < 16; i++) b[i] = words[16 + i];
    xpose(b, 1'b1, eb);
    check("stall accepted count", acc, 32);
    check("stall in_ready low", in_ready, 1'b0);
    check("stall out_valid", out_valid, 1'b1);
    check("stall out_data stable", out_data, snap);
    check("stall out_data word0", out_data, ea[0]);
    for (int j = 0; j < 32; j++) begin
      check($sformatf("drain out_valid[%0d]", j), out_valid, 1'b1);
      check($sformatf("drain out_data[%0d]", j), out_data, (j < 16) ? ea[j] : eb[j-16]);
      check($sformatf("drain out_last[%0d]", j), out_last, (j % 16) == 15);
      out_ready = 1'b1;
      @(negedge clk);
      if (j == 15) check("drain in_ready back", in_ready, 1'b1);
    end
    check("drain idle", out_valid, 1'b0);

    // Reset mid-block with a full drain sitting on its last word.
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'($urandom); in_mirror = 1'b0;
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (i < 7);
      in_data   = 16'hA5A5 ^ 16'(i);
    end
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    check("pre-reset out_last", out_last, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async reset out_valid", out_valid, 1'b0);
    check("async reset out_last", out_last, 1'b0);
    check("async reset in_ready", in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) b[i] = 16'($urandom);
    xpose(b, 1'b0, e);
    run_block(b, 1'b0, e, "post-reset");

    // N=2 build: rows 01,11 -> columns 11,10; mirrored -> 10,11.
    n2_out_ready = 1'b1;
    for (int m = 0; m < 2; m++) begin
      @(negedge clk);
      n2_in_valid = 1'b1; n2_in_data = 2'b01; n2_in_mirror = (m == 1);
      @(negedge clk);
      n2_in_data = 2'b11; n2_in_mirror = (m == 0);
      @(negedge clk);
      n2_in_valid = 1'b0;
      check($sformatf("n2 m%0d valid0", m), n2_out_valid, 1'b1);
      check($sformatf("n2 m%0d data0", m), n2_out_data, (m == 1) ? 2'b10 : 2'b11);
      check($sformatf("n2 m%0d last0", m), n2_out_last, 1'b0);
      @(negedge clk);
      check($sformatf("n2 m%0d data1", m), n2_out_data, (m == 1) ? 2'b11 : 2'b10);
      check($sformatf("n2 m%0d last1", m), n2_out_last, 1'b1);
      @(negedge clk);
      check($sformatf("n2 m%0d idle", m), n2_out_valid, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bit_matrix_transposer.md
# bit_matrix_transposer

Parametrised, double-buffered N×N bit-matrix transposer for the block-matching bit-pixel path. It accepts N-bit row words (one bit per image row lane) and emits N-bit column words, so column-serial binary pixel streams become row-parallel words for the census/matching stages. Unlike the fixed 16×16 rotator, it has a configurable size, ready/valid backpressure on both sides, a per-block mirror mode, and a block-end marker.

## Interface
- N, 16, matrix dimension and word width; legal range 2..64.
- CW, $clog2(N), counter width (derived; not overridden).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  N  row word; bit j of block word k is element (k,j).
- in_valid  in  1  in_data valid.
- in_ready  out  1  word accepted on a cycle where in_valid && in_ready.
- in_mirror  in  1  mode for the block; sampled with that block's first accepted word.
- out_data  out  N  column word; bit k of output word j is element (k,j).
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts on a cycle where out_valid && out_ready.
- out_last  out  1  high with the final (Nth) word of each output block.

## Operation
- Two N×N buffers: fill (input side) and drain (output side).
- Fill: each accepted word shifts into the fill buffer and increments in_cnt (0..N-1, wraps to 0 after N-1). When in_cnt == 0 on acceptance, capture in_mirror into fill_mirror.
- Block complete: the word accepted with in_cnt == N-1.
- Transfer: move the complete block and fill_mirror into the drain buffer on the completing edge if the drain is free. The drain is free if it is empty, or if its last word is being accepted in the same cycle (out_valid && out_ready && out_last).
  - If the drain is busy, set fill_full. While fill_full is set, in_ready = 0.
  - Transfer on the first edge where the drain frees, then clear fill_full.
- in_ready = !fill_full (registered state, no combinational path from out_ready).
- Drain: out_cnt counts 0..N-1.
  - mirror = 0: column word j = out_cnt.
  - mirror = 1: column word j = N-1-out_cnt.
  - out_cnt advances only on out_valid && out_ready.
  - out_last = out_valid && (out_cnt == N-1).
  - After the last word is accepted, the drain becomes empty unless a transfer occurs on the same edge, in which case out_valid stays 1 and out_cnt restarts at 0.
- out_data is held stable while out_valid && !out_ready.
- Simultaneous events:
  - A transfer and the last-word drain on the same edge is legal and loses no cycle.
  - An input word accepted on the same edge fill_full clears is impossible, because in_ready was 0.
- Reset, asynchronous and at any time including mid-block:
  - in_cnt = 0, out_cnt = 0, fill_full = 0, out_valid = 0, out_last = 0, in_ready = 1, fill_mirror = 0.
  - Partial blocks are discarded.
  - Buffer data registers are not reset; out_data is don't-care while out_valid = 0.

## Timing
- Latency: the last input word accepted on edge t, with the drain free, gives out_valid = 1 with column word 0 (or N-1 if mirrored) during the cycle after edge t.
- Throughput: with out_ready held high and in_valid held high, one word per cycle is sustained indefinitely and in_ready never drops.
- Stall: with out_ready low, at most 2N words are accepted before in_ready falls. in_ready rises the cycle after the drain frees.
- All outputs are registered or decoded only from registered state. in_ready and out_valid have no combinational dependence on in_valid or out_ready.

## Test plan
- N=16, out_ready=1, mirror=0. Input word 3 = 16'hFFFF, all others 0 -> 16 output words all 16'h0008; out_last only on the 16th; first output one cycle after the 16th input.
- N=16, mirror=1. Word 0 = 16'h0001, others 0 -> output words 0..14 = 0, word 15 = 16'h0001 with out_last. With mirror=0 the same input gives word 0 = 16'h0001.
- Back-to-back: 4 blocks of random data, in_valid and out_ready held high -> in_ready constantly 1; 64 outputs on consecutive cycles, each matching the bit-exact transpose model.
- Backpressure: out_ready=0 and in_valid=1 -> exactly 32 words accepted, then in_ready=0; out_data stable. Raising out_ready drains 16 words, the next block follows with no gap, and in_ready returns to 1.
- Reset mid-block: assert reset after 7 of 16 words -> all outputs take their reset values immediately. After release, a fresh 16-word block transposes correctly with no residue from the 7 words.
- N=8 and N=2 builds: random blocks with random in_valid/out_ready toggling -> outputs match the model, out_last every N words, no word lost or duplicated.
